// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM encoding, nibble width and 1-bit full-adder cell for the serial ALU blocks.
package alu_pkg;
    localparam int NIBBLE = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction
endpackage

// File: rtl/sub_nibble4.sv
// sub_nibble4: combinational 4-bit slice computing a + ~b + cin from chained full-adder cells.
module sub_nibble4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign {c[i+1], sum[i]} = full_add(a[i], ~b[i], c[i]);
    end
    assign cout = c[4];
endmodule

// File: rtl/serial_sub64.sv
// serial_sub64: nibble-serial unsigned subtractor, one nibble per cycle, LSB first.
// Optional result flags (zero/negative/overflow) enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_sub64
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    localparam int NN = WIDTH / NIBBLE;
    localparam int CW = $clog2(NN);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic             cin_q, cin_d, borrow_q, borrow_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [3:0]       sum;
    logic             cout;
    logic             last;

    sub_nibble4 u_nib (
        .a   (a_q[3:0]),
        .b   (b_q[3:0]),
        .cin (cin_q),
        .sum (sum),
        .cout(cout)
    );

    assign last = (cnt_q == CW'(NN - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cin_d    = cin_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? BUSY : IDLE;
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    cnt_d  = '0;
                    cin_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            BUSY: begin
                // Operands drain from the LSB end while results fill from the MSB end.
                a_d    = a_q >> NIBBLE;
                b_d    = b_q >> NIBBLE;
                diff_d = {sum, diff_q[WIDTH-1:NIBBLE]};
                cin_d  = cout;
                cnt_d  = cnt_q + 1'b1;
                busy_d = !last;
                done_d = last;
                if (last) begin
                    state_d  = DONE;
                    borrow_d = ~cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cin_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cin_q    <= cin_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, zero_d, negative_q, negative_d, overflow_q, overflow_d;

    // On the last nibble a_q[3]/b_q[3] hold the original operand sign bits.
    always_comb begin
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        if (state_q == BUSY && last) begin
            zero_d     = (diff_d == '0);
            negative_d = sum[3];
            overflow_d = (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
    assign overflow = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
endmodule
